// File: rtl/cache_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : cache_ram_bridge
// Brief    : Splits a cache-line request into word beats on a single-port RAM
//            handshake and pulses a response when the whole line is done.
//            Optional RAM_TIMEOUT_EN adds a per-beat ack watchdog (bus_err).
// Revision : 1.0 - initial release
// ============================================================================
module cache_ram_bridge #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int TIMEOUT    = 255
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         enable_cache_to_ram,
    input  logic                         write_cache_to_ram,
    input  logic [ADDR_W-1:0]            addr_cache_to_ram,
    input  logic [WORD_W*LINE_WORDS-1:0] line_wdata,
    output logic [WORD_W*LINE_WORDS-1:0] line_rdata,
    output logic                         response_ram_to_cache,
    output logic                         busy,
    output logic                         ram_req,
    output logic                         ram_we,
    output logic [ADDR_W-1:0]            ram_addr,
    output logic [WORD_W-1:0]            ram_wdata,
    input  logic [WORD_W-1:0]            ram_rdata,
    input  logic                         ram_ack,
    output logic                         bus_err
);

    localparam int c_BYTES  = WORD_W / 8;
    localparam int c_OFF    = $clog2(LINE_WORDS * c_BYTES);
    localparam int c_CNT_W  = $clog2(LINE_WORDS);
    localparam int c_LINE_W = WORD_W * LINE_WORDS;
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(LINE_WORDS - 1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_BEAT = 2'd1;
    localparam logic [1:0] c_RESP = 2'd2;

    logic [1:0]          r_state;
    logic [c_CNT_W-1:0]  r_beat;
    logic [ADDR_W-1:0]   r_base;
    logic                r_we;
    logic [c_LINE_W-1:0] r_wdata;
    logic [c_LINE_W-1:0] r_rdata;
    logic                r_abort;
    logic                w_abort;

`ifdef RAM_TIMEOUT_EN
    localparam int c_WAIT_W = $clog2(TIMEOUT + 1);
    localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(TIMEOUT - 1);

    logic [c_WAIT_W-1:0] r_wait;
    logic                r_bus_err;

    assign bus_err = r_bus_err;
`else
    assign bus_err = 1'b0;
`endif

    assign busy                  = (r_state != c_IDLE);
    assign ram_req               = (r_state == c_BEAT);
    assign response_ram_to_cache = (r_state == c_RESP);
    assign ram_we                = r_we;
    // Address arithmetic wraps silently at the top of the address space.
    assign ram_addr              = r_base + ADDR_W'(r_beat) * ADDR_W'(c_BYTES);
    assign ram_wdata             = r_wdata[int'(r_beat)*WORD_W +: WORD_W];
    assign line_rdata            = r_rdata;

    // A dropped enable is remembered so the pending beat can finish first.
    assign w_abort = r_abort | ~enable_cache_to_ram;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= c_IDLE;
            r_beat    <= '0;
            r_base    <= '0;
            r_we      <= 1'b0;
            r_wdata   <= '0;
            r_rdata   <= '0;
            r_abort   <= 1'b0;
`ifdef RAM_TIMEOUT_EN
            r_wait    <= '0;
            r_bus_err <= 1'b0;
`endif
        end else begin
`ifdef RAM_TIMEOUT_EN
            r_bus_err <= 1'b0;
`endif
            case (r_state)
                c_IDLE: begin
                    if (enable_cache_to_ram) begin
                        r_base  <= {addr_cache_to_ram[ADDR_W-1:c_OFF], {c_OFF{1'b0}}};
                        r_we    <= write_cache_to_ram;
                        r_wdata <= line_wdata;
                        r_beat  <= '0;
                        r_abort <= 1'b0;
                        r_state <= c_BEAT;
`ifdef RAM_TIMEOUT_EN
                        r_wait  <= '0;
`endif
                    end
                end
                c_BEAT: begin
                    if (!enable_cache_to_ram) begin
                        r_abort <= 1'b1;
                    end
                    if (ram_ack) begin
                        if (!r_we) begin
                            r_rdata[int'(r_beat)*WORD_W +: WORD_W] <= ram_rdata;
                        end
`ifdef RAM_TIMEOUT_EN
                        r_wait <= '0;
`endif
                        if (w_abort) begin
                            r_state <= c_IDLE;
                        end else if (r_beat == c_LAST) begin
                            r_state <= c_RESP;
                        end else begin
                            r_beat <= r_beat + c_CNT_W'(1);
                        end
                    end
`ifdef RAM_TIMEOUT_EN
                    else if (r_wait == c_WAIT_LAST) begin
                        r_state   <= c_IDLE;
                        r_bus_err <= 1'b1;
                    end else begin
                        r_wait <= r_wait + c_WAIT_W'(1);
                    end
`endif
                end
                c_RESP: begin
                    r_state <= c_IDLE;
                end
                default: begin
                    r_state <= c_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_ram_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_cache_ram_bridge
// Brief    : Scoreboard bench for cache_ram_bridge with a delay-capable RAM model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_cache_ram_bridge;

    localparam int ADDR_W     = 32;
    localparam int WORD_W     = 32;
    localparam int LINE_WORDS = 4;
`ifdef RAM_TIMEOUT_EN
    localparam int TMO = 8;
`else
    localparam int TMO = 255;
`endif

    logic         clk;
    logic         rst;
    logic         enable_cache_to_ram;
    logic         write_cache_to_ram;
    logic [31:0]  addr_cache_to_ram;
    logic [127:0] line_wdata;
    logic [127:0] line_rdata;
    logic         response_ram_to_cache;
    logic         busy;
    logic         ram_req;
    logic         ram_we;
    logic [31:0]  ram_addr;
    logic [31:0]  ram_wdata;
    logic [31:0]  ram_rdata;
    logic         ram_ack;
    logic         bus_err;

    cache_ram_bridge #(
        .ADDR_W     (ADDR_W),
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS),
        .TIMEOUT    (TMO)
    ) dut (
        .clk                   (clk),
        .rst                   (rst),
        .enable_cache_to_ram   (enable_cache_to_ram),
        .write_cache_to_ram    (write_cache_to_ram),
        .addr_cache_to_ram     (addr_cache_to_ram),
        .line_wdata            (line_wdata),
        .line_rdata            (line_rdata),
        .response_ram_to_cache (response_ram_to_cache),
        .busy                  (busy),
        .ram_req               (ram_req),
        .ram_we                (ram_we),
        .ram_addr              (ram_addr),
        .ram_wdata             (ram_wdata),
        .ram_rdata             (ram_rdata),
        .ram_ack               (ram_ack),
        .bus_err               (bus_err)
    );

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } beat_t;

    beat_t        beat_q[$];
    logic [127:0] line_q[$];
    logic [127:0] model_line = '0;
    int           vectors = 0;
    int           errors  = 0;

    logic [31:0]  rdata_seed   = '0;
    logic [31:0]  delay_addr   = '1;
    int           delay_cycles = 0;
    bit           no_ack       = 1'b0;
    int           wait_cnt     = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // RAM model: checks each new beat against the scoreboard, then acks after
    // the configured delay with data derived from the word address.
    always @(negedge clk) begin
        beat_t b;
        if (rst || !ram_req) begin
            ram_ack  = 1'b0;
            wait_cnt = 0;
        end else begin
            if (wait_cnt == 0) begin
                vectors++;
                if (beat_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got we=%b addr=%h, required no beat", ram_we, ram_addr);
                end else begin
                    b = beat_q.pop_front();
                    if (ram_we !== b.we || ram_addr !== b.addr || (b.we && ram_wdata !== b.wdata)) begin
                        errors++;
                        $display("FAIL beat: got we=%b addr=%h wdata=%h, required we=%b addr=%h wdata=%h",
                                 ram_we, ram_addr, ram_wdata, b.we, b.addr, b.wdata);
                    end
                end
            end
            if (!no_ack && wait_cnt >= ((ram_addr == delay_addr) ? delay_cycles : 0)) begin
                ram_ack   = 1'b1;
                ram_rdata = rdata_seed + {30'd0, ram_addr[3:2]};
                wait_cnt  = 0;
            end else begin
                ram_ack = 1'b0;
                wait_cnt++;
            end
        end
    end

    // Every response pulse must present the line the scoreboard predicts.
    always @(negedge clk) begin
        logic [127:0] exp_line;
        if (!rst && response_ram_to_cache) begin
            vectors++;
            if (line_q.size() == 0) begin
                errors++;
                $display("FAIL resp_unexpected: got response, required none");
            end else begin
                exp_line = line_q.pop_front();
                if (line_rdata !== exp_line) begin
                    errors++;
                    $display("FAIL resp_line: got %h, required %h", line_rdata, exp_line);
                end
            end
        end
    end

    task automatic expect_line(input logic we, input logic [31:0] addr, input logic [31:0] seed,
                               input logic [127:0] wd, input int nbeats, input bit resp);
        beat_t b;
        logic [31:0] base;
        base = {addr[31:4], 4'h0};
        for (int k = 0; k < nbeats; k++) begin
            b.we    = we;
            b.addr  = base + 32'(k * 4);
            b.wdata = wd[k*32 +: 32];
            beat_q.push_back(b);
            if (!we) model_line[k*32 +: 32] = seed + 32'(k);
        end
        if (resp) line_q.push_back(model_line);
    endtask

    task automatic start_req(input logic we, input logic [31:0] addr, input logic [127:0] wd);
        @(negedge clk);
        enable_cache_to_ram = 1'b1;
        write_cache_to_ram  = we;
        addr_cache_to_ram   = addr;
        line_wdata          = wd;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        enable_cache_to_ram = 1'b0;
        write_cache_to_ram  = 1'b0;
        addr_cache_to_ram   = '0;
        line_wdata          = '0;
        ram_ack             = 1'b0;
        ram_rdata           = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vectors++; if (ram_req !== 1'b0) begin errors++; $display("FAIL rst_ram_req: got %b, required 0", ram_req); end
        vectors++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
        vectors++; if (response_ram_to_cache !== 1'b0) begin errors++; $display("FAIL rst_resp: got %b, required 0", response_ram_to_cache); end
        vectors++; if (line_rdata !== 128'd0) begin errors++; $display("FAIL rst_line: got %h, required 0", line_rdata); end
        vectors++; if (bus_err !== 1'b0) begin errors++; $display("FAIL rst_bus_err: got %b, required 0", bus_err); end
        vectors++; if (ram_addr !== 32'd0 || ram_we !== 1'b0) begin errors++; $display("FAIL rst_addr_we: got %h/%b, required 0/0", ram_addr, ram_we); end
        rst = 1'b0;
    endtask

    task automatic test_refill;
        int lat = 0;
        rdata_seed = 32'hA0;
        expect_line(1'b0, 32'h104, 32'hA0, '0, 4, 1'b1);
        start_req(1'b0, 32'h104, '0);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                vectors++;
                if (ram_req !== 1'b1) begin errors++; $display("FAIL refill_latency: got ram_req=%b, required 1", ram_req); end
            end
            if (response_ram_to_cache) begin
                lat = c;
                enable_cache_to_ram = 1'b0;
                break;
            end
        end
        vectors++;
        if (lat != 5) begin errors++; $display("FAIL refill_cycles: got response at %0d, required 5", lat); end
        @(negedge clk);
        vectors++;
        if (response_ram_to_cache !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL refill_pulse_end: got resp=%b busy=%b, required 0/0", response_ram_to_cache, busy);
        end
        vectors++;
        if (line_rdata !== 128'h000000A3_000000A2_000000A1_000000A0) begin
            errors++; $display("FAIL refill_line: got %h, required 000000a3000000a2000000a1000000a0", line_rdata);
        end
    endtask

    task automatic test_back_to_back;
        int pulses = 0;
        logic [127:0] wd;
        wd = 128'hDEAD0003_DEAD0002_DEAD0001_DEAD0000;
        rdata_seed = 32'hB0;
        expect_line(1'b1, 32'h200, 32'h0, wd, 4, 1'b1);
        expect_line(1'b0, 32'h200, 32'hB0, '0, 4, 1'b1);
        start_req(1'b1, 32'h200, wd);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (response_ram_to_cache) begin
                pulses++;
                if (pulses == 1) write_cache_to_ram = 1'b0;
                if (pulses == 2) begin enable_cache_to_ram = 1'b0; break; end
            end
        end
        repeat (3) begin
            @(negedge clk);
            if (response_ram_to_cache) pulses++;
        end
        vectors++;
        if (pulses != 2) begin errors++; $display("FAIL b2b_pulses: got %0d, required 2", pulses); end
        @(posedge clk); #1;
        vectors++;
        if (beat_q.size() != 0) begin errors++; $display("FAIL b2b_beats_left: got %0d, required 0", beat_q.size()); end
    endtask

    task automatic test_ack_delay;
        int held = 0;
        bit seen = 0;
        logic [127:0] wd;
        wd = 128'h33333333_22222222_11111111_00000000;
        delay_addr   = 32'h108;
        delay_cycles = 3;
        expect_line(1'b1, 32'h100, 32'h0, wd, 4, 1'b1);
        start_req(1'b1, 32'h100, wd);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (ram_req && ram_addr == 32'h108) begin
                held++;
                vectors++;
                if (ram_wdata !== 32'h22222222 || ram_we !== 1'b1) begin
                    errors++; $display("FAIL delay_hold: got wdata=%h we=%b, required 22222222/1", ram_wdata, ram_we);
                end
            end
            if (response_ram_to_cache) begin seen = 1; enable_cache_to_ram = 1'b0; break; end
        end
        vectors++;
        if (held != 4) begin errors++; $display("FAIL delay_held_cycles: got %0d, required 4", held); end
        vectors++;
        if (!seen) begin errors++; $display("FAIL delay_resp: got none, required 1 pulse"); end
        delay_addr = '1;
    endtask

    task automatic test_abort;
        int  held = 0;
        bit  resp_seen = 0;
        rdata_seed   = 32'hC0;
        delay_addr   = 32'h404;
        delay_cycles = 3;
        expect_line(1'b0, 32'h400, 32'hC0, '0, 2, 1'b0);
        start_req(1'b0, 32'h400, '0);
        for (int c = 1; c <= 12; c++) begin
            @(negedge clk);
            if (response_ram_to_cache) resp_seen = 1;
            if (ram_req && ram_addr == 32'h404) begin
                held++;
                if (held == 1) enable_cache_to_ram = 1'b0;
            end
        end
        vectors++;
        if (held != 4) begin errors++; $display("FAIL abort_req_held: got %0d, required 4", held); end
        vectors++;
        if (resp_seen) begin errors++; $display("FAIL abort_resp: got pulse, required none"); end
        vectors++;
        if (busy !== 1'b0 || ram_req !== 1'b0) begin errors++; $display("FAIL abort_idle: got busy=%b req=%b, required 0/0", busy, ram_req); end
        vectors++;
        if (line_rdata !== model_line) begin errors++; $display("FAIL abort_line: got %h, required %h", line_rdata, model_line); end
        vectors++;
        if (beat_q.size() != 0) begin errors++; $display("FAIL abort_beats_left: got %0d, required 0", beat_q.size()); end
        delay_addr = '1;
    endtask

    task automatic test_reset_mid;
        bit reached = 0;
        bit seen = 0;
        rdata_seed   = 32'h50;
        delay_addr   = 32'h508;
        delay_cycles = 5;
        expect_line(1'b0, 32'h500, 32'h50, '0, 4, 1'b1);
        start_req(1'b0, 32'h500, '0);
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (ram_req && ram_addr == 32'h508) begin reached = 1; break; end
        end
        vectors++;
        if (!reached) begin errors++; $display("FAIL rstmid_reach: got no beat 2, required beat at 00000508"); end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if (ram_req !== 1'b0 || busy !== 1'b0 || response_ram_to_cache !== 1'b0) begin
            errors++; $display("FAIL rstmid_async: got req=%b busy=%b resp=%b, required 0/0/0", ram_req, busy, response_ram_to_cache);
        end
        vectors++;
        if (line_rdata !== 128'd0) begin errors++; $display("FAIL rstmid_line: got %h, required 0", line_rdata); end
        beat_q.delete();
        line_q.delete();
        model_line = '0;
        enable_cache_to_ram = 1'b0;
        delay_addr = '1;
        @(negedge clk);
        rst = 1'b0;
        rdata_seed = 32'hE0;
        expect_line(1'b0, 32'h300, 32'hE0, '0, 4, 1'b1);
        start_req(1'b0, 32'h300, '0);
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (response_ram_to_cache) begin seen = 1; enable_cache_to_ram = 1'b0; break; end
        end
        vectors++;
        if (!seen) begin errors++; $display("FAIL rstmid_refill: got no response, required 1"); end
        @(negedge clk);
        vectors++;
        if (line_rdata !== 128'h000000E3_000000E2_000000E1_000000E0) begin
            errors++; $display("FAIL rstmid_line_after: got %h, required 000000e3000000e2000000e1000000e0", line_rdata);
        end
    endtask

`ifdef RAM_TIMEOUT_EN
    task automatic test_timeout;
        beat_t b;
        int  req_cycles = 0;
        bit  err_seen = 0;
        bit  resp_seen = 0;
        no_ack  = 1'b1;
        b.we    = 1'b0;
        b.addr  = 32'h600;
        b.wdata = '0;
        beat_q.push_back(b);
        start_req(1'b0, 32'h600, '0);
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            if (response_ram_to_cache) resp_seen = 1;
            if (ram_req) req_cycles++;
            if (bus_err) begin
                err_seen = 1;
                enable_cache_to_ram = 1'b0;
                vectors++;
                if (ram_req !== 1'b0 || busy !== 1'b0) begin
                    errors++; $display("FAIL tmo_idle: got req=%b busy=%b, required 0/0", ram_req, busy);
                end
                break;
            end
        end
        vectors++;
        if (!err_seen || req_cycles != 8) begin
            errors++; $display("FAIL tmo_cycles: got err=%b after %0d waits, required 1 after 8", err_seen, req_cycles);
        end
        vectors++;
        if (resp_seen) begin errors++; $display("FAIL tmo_resp: got pulse, required none"); end
        @(negedge clk);
        vectors++;
        if (bus_err !== 1'b0) begin errors++; $display("FAIL tmo_pulse: got bus_err=%b, required 0", bus_err); end
        no_ack = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_refill();
        test_back_to_back();
        test_ack_delay();
        test_abort();
        test_reset_mid();
`ifdef RAM_TIMEOUT_EN
        test_timeout();
`endif
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_ram_bridge.md
Name: cache_ram_bridge

Overview:
- Memory-side stage directly downstream of the cache controller.
- Converts the controller's line-level request (enable_cache_to_ram, write_cache_to_ram) into a sequence of word beats on a single-port RAM handshake.
- Returns response_ram_to_cache as a one-cycle pulse when a whole line has been written back or refilled.
- Serves both the write-back and the refill phases of a dirty miss, which the controller issues back-to-back with enable held high.

Parameters:
ADDR_W, 32, byte address width
WORD_W, 32, RAM word width in bits; multiple of 8
LINE_WORDS, 4, words per cache line; power of two, >= 2
TIMEOUT, 255, max cycles waiting for one ram_ack (used only with RAM_TIMEOUT_EN)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
enable_cache_to_ram  in  1  line request valid; level, held by controller until response
write_cache_to_ram  in  1  1 = write-back line_wdata, 0 = refill into line_rdata
addr_cache_to_ram  in  ADDR_W  line byte address; offset bits ignored
line_wdata  in  WORD_W*LINE_WORDS  write-back data; word k in bits [k*WORD_W +: WORD_W]
line_rdata  out  WORD_W*LINE_WORDS  refilled line, same packing
response_ram_to_cache  out  1  one-cycle pulse: line transfer complete
busy  out  1  high whenever state != IDLE
ram_req  out  1  beat request; held until ram_ack
ram_we  out  1  beat is a write
ram_addr  out  ADDR_W  beat byte address
ram_wdata  out  WORD_W  beat write data
ram_rdata  in  WORD_W  read data; valid in the ram_ack cycle
ram_ack  in  1  beat accepted/completed this cycle
bus_err  out  1  one-cycle pulse on RAM timeout; tied 0 without macro

Behaviour:
- Reset (asynchronous, immediate): state IDLE, beat counter 0, all outputs 0, line_rdata 0, any in-flight beat abandoned.
- OFF = log2(LINE_WORDS*WORD_W/8). Base address = addr_cache_to_ram with bits [OFF-1:0] cleared.
- Beat k address = base + k*(WORD_W/8), computed modulo 2^ADDR_W, so wrap past the top of memory is silent.
- IDLE:
  - If enable_cache_to_ram=1, latch base, write_cache_to_ram and line_wdata; beat counter = 0; go to BEAT.
  - ram_req rises on the next cycle, so latency from request to first ram_req is 1 cycle.
- BEAT:
  - ram_req=1; ram_we = latched write; ram_addr = beat address; ram_wdata = latched word k.
  - Outputs stay stable while ram_ack=0.
  - On ram_ack with a read, write ram_rdata into line_rdata word k; only that word changes.
  - On ram_ack with k < LINE_WORDS-1, increment k. ram_req stays high, so the next beat is presented the following cycle.
  - On ram_ack with k = LINE_WORDS-1, go to RESP.
- RESP:
  - response_ram_to_cache=1 for exactly this cycle; ram_req=0; then return to IDLE.
  - enable_cache_to_ram is not sampled in RESP.
  - A request still held in the cycle after RESP is treated as a new transaction. This covers the write-back followed by refill sequence.
- Abort:
  - If enable_cache_to_ram falls during BEAT, the current beat keeps ram_req high until its ram_ack; ram_req is never withdrawn without an ack.
  - After that ack, go to IDLE with no response pulse.
  - Words already refilled remain in line_rdata.
- line_rdata is stable from the response pulse until the first ack of the next refill.
- Inputs changing mid-transaction are ignored because all request fields are latched.
- Simultaneous ram_ack and enable fall on the same cycle: the beat completes and the bridge aborts as described above.
- Minimum transaction length: 1 + LINE_WORDS + 1 cycles with ram_ack tied high.

Optional Feature:
- Macro: RAM_TIMEOUT_EN.
- Defined:
  - A wait counter resets on every ram_ack and on entry to BEAT, and increments each BEAT cycle with ram_ack=0.
  - When the counter reaches TIMEOUT, drop ram_req, pulse bus_err for 1 cycle, go to IDLE, and issue no response pulse.
  - A late ram_ack arriving in IDLE is ignored.
- Undefined: no counter logic is built, bus_err is constant 0, and the bridge waits indefinitely.

Test Plan:
- Refill, addr 0x104, ram_ack tied 1, rdata 0xA0,0xA1,0xA2,0xA3 -> ram_addr 0x100,0x104,0x108,0x10C with ram_we=0; line_rdata = 0x000000A3_000000A2_000000A1_000000A0; response pulse 1 cycle; 6 cycles total.
- Write-back then refill: enable held high, write 1 then 0 after the first response, addr 0x200 -> four write beats carrying line_wdata words 0..3, then four read beats at 0x200..0x20C; exactly two response pulses.
- ram_ack delayed 3 cycles on beat 2 -> ram_req, ram_addr 0x108 and ram_wdata held for 4 cycles; no duplicate beat; response still issued.
- Enable drops while beat 1 is waiting for ack -> ram_req held until the ack, then IDLE with no response; line_rdata word 0 updated, words 2-3 unchanged.
- rst asserted mid-beat 2 -> ram_req, busy and response go to 0 in the same cycle, before the next clock edge; after release, a fresh refill at 0x300 completes normally.
- RAM_TIMEOUT_EN, TIMEOUT=8, ram_ack never asserted -> bus_err pulse after 8 wait cycles, ram_req 0, state IDLE, no response pulse.
